// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write port arbiter: pipeline writeback vs external loader.
// Round-robin on ties, bounded external burst ownership, one forced writeback slot after a burst.
module regfile_write_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              ext_valid,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_lock,
    output logic              ext_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_last_grant_o,
    output logic [3:0]        dbg_burst_cnt_o
);

    // Handshake: a requester transfers on a rising edge where its valid and ready are both 1.
    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_BURST = 2'd1,
        ST_YIELD = 2'd2
    } state_e;

    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              grant_wb, grant_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RR;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    // Grant logic: a lone requester always wins; ties depend on state.
    always_comb begin
        grant_wb  = 1'b0;
        grant_ext = 1'b0;
        if (wb_valid && ext_valid) begin
            case (state_q)
                ST_YIELD: grant_wb = 1'b1;
                ST_BURST: begin
                    if (ext_lock)          grant_ext = 1'b1;
                    else if (last_grant_q) grant_wb  = 1'b1;
                    else                   grant_ext = 1'b1;
                end
                default: begin
                    if (last_grant_q) grant_wb  = 1'b1;
                    else              grant_ext = 1'b1;
                end
            endcase
        end else begin
            grant_wb  = wb_valid;
            grant_ext = ext_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        if (grant_ext)     last_grant_d = 1'b1;
        else if (grant_wb) last_grant_d = 1'b0;

        case (state_q)
            ST_RR: begin
                if (grant_ext && ext_lock) begin
                    burst_cnt_d = 4'd1;
                    state_d     = (BURST_MAX_C == 4'd1) ? ST_YIELD : ST_BURST;
                end
            end
            ST_BURST: begin
                if (!ext_lock) begin
                    state_d     = ST_RR;
                    burst_cnt_d = 4'd0;
                end else if (grant_ext) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q + 4'd1 == BURST_MAX_C) state_d = ST_YIELD;
                end
            end
            default: begin
                state_d     = ST_RR;
                burst_cnt_d = 4'd0;
            end
        endcase

        rf_we_d    = grant_wb | grant_ext;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_ext) begin
            rf_waddr_d = ext_addr;
            rf_wdata_d = ext_data;
        end else if (grant_wb) begin
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end
    end

    assign wb_ready         = grant_wb;
    assign ext_ready        = grant_ext;
    assign stall            = wb_valid & ~grant_wb;
    assign rf_we            = rf_we_q;
    assign rf_waddr         = rf_waddr_q;
    assign rf_wdata         = rf_wdata_q;
    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;
    assign dbg_burst_cnt_o  = burst_cnt_q;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 4, register number width.
REQ-003 Parameter BURST_MAX, default 4, max consecutive locked external writes; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-006 wb_valid  input  1  pipeline writeback request.
REQ-007 wb_addr  input  ADDR_W  writeback destination register.
REQ-008 wb_data  input  DATA_W  writeback data.
REQ-009 wb_ready  output  1  writeback granted this cycle (combinational).
REQ-010 ext_valid  input  1  external loader/debug write request.
REQ-011 ext_addr  input  ADDR_W  external destination register.
REQ-012 ext_data  input  DATA_W  external write data.
REQ-013 ext_lock  input  1  external requests burst ownership.
REQ-014 ext_ready  output  1  external write granted this cycle (combinational).
REQ-015 rf_we  output  1  register file write enable, registered.
REQ-016 rf_waddr  output  ADDR_W  register file write number, registered.
REQ-017 rf_wdata  output  DATA_W  register file write data, registered.
REQ-018 stall  output  1  pipeline hold: wb_valid and not wb_ready (combinational).

Function
REQ-019 Transfer occurs on an edge where valid and ready are both 1 for a requester; at most one transfer per cycle.
REQ-020 wb_ready and ext_ready are never 1 in the same cycle; a ready is never 1 while its valid is 0.
REQ-021 Arbiter is work-conserving: if exactly one valid is 1, that requester is granted in every state.
REQ-022 State machine states: RR, BURST, YIELD; plus last_grant flag (0=wb, 1=ext) and burst_cnt (4 bits).
REQ-023 RR, both valid: grant requester opposite last_grant; last_grant updates to the granted side on every transfer in any state.
REQ-024 RR -> BURST when an ext transfer occurs with ext_lock=1; burst_cnt set to 1 (to YIELD instead if BURST_MAX=1).
REQ-025 BURST, both valid: ext granted; each ext transfer increments burst_cnt.
REQ-026 BURST -> YIELD on the ext transfer that makes burst_cnt equal BURST_MAX.
REQ-027 BURST with ext_lock=0: that cycle arbitrates as RR; next state RR, burst_cnt cleared.
REQ-028 YIELD, both valid: wb granted regardless of last_grant; YIELD lasts exactly one cycle, then RR, burst_cnt cleared.
REQ-029 Write latency 1 cycle: edge after a transfer, rf_we=1 with rf_waddr/rf_wdata equal to the granted requester's addr/data.
REQ-030 No transfer: rf_we=0; rf_waddr/rf_wdata hold last values.
REQ-031 Same addr from both requesters in one cycle: only granted write issues; loser's write issues on a later grant, never merged or dropped.
REQ-032 Maximum wb wait with both valid continuously: BURST_MAX cycles.

Reset
REQ-033 reset=0: rf_we=0, rf_waddr=0, rf_wdata=0, state=RR, last_grant=1, burst_cnt=0, asynchronously.
REQ-034 Reset mid-burst aborts burst; first tie after release grants wb.
REQ-035 wb_ready/ext_ready/stall during reset follow REQ-021/023 from reset state values.

Verification (BURST_MAX=4)
REQ-036 After reset, wb_valid=1 addr 3 data 0x5A, ext_valid=1 addr 7 data 0x11 held -> cycle0 wb granted, cycle1 ext, alternating; rf_we pulses each cycle, first write (3,0x5A) one cycle after grant.
REQ-037 ext_lock=1, ext_valid and wb_valid held high -> 4 consecutive ext grants, stall=1 for those 4 cycles, then 1 wb grant (YIELD), then RR alternation.
REQ-038 ext_lock dropped after 2 locked ext transfers, both valid -> next cycle wb granted, state RR, burst_cnt=0.
REQ-039 Only wb_valid=1 during BURST -> wb granted immediately, stall=0, burst_cnt unchanged.
REQ-040 Both requesters target addr 5 (wb 0xAA, ext 0xBB), after reset -> rf_we cycles show (5,0xAA) then (5,0xBB); no cycle lacks a write while a request is pending.
REQ-041 reset asserted asynchronously mid-burst between edges -> rf_we drops to 0 immediately; after release, tie grants wb.
